// File: rtl/hist_cdf_lut.sv
// Luma histogram equalization LUT generator: accumulates a 256-bin histogram per frame,
// converts it to a CDF-based 8-bit LUT in blanking, and publishes it via a double-buffered port.
module hist_cdf_lut #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned CNT_W    = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel_valid_in,
  input  logic       frame_start,
  input  logic [7:0] luma_in,
  input  logic [7:0] lut_rd_addr,
  output logic [7:0] lut_rd_data,
  output logic       lut_ready,
  output logic       busy,
  output logic       pix_dropped
);

  localparam int unsigned N = H_ACTIVE * V_ACTIVE;
  localparam longint unsigned SCALE = ((64'd255 << 24) + 64'(N) - 64'd1) / 64'(N);
  localparam int unsigned SCALE_W = $clog2(SCALE + 64'd1);
  localparam int unsigned PROD_W  = CNT_W + SCALE_W;
  localparam int unsigned HI_W    = PROD_W - 24;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(N - 1);
  localparam logic [SCALE_W-1:0] SCALE_V  = SCALE_W'(SCALE);

  typedef enum logic [2:0] {StInit, StAccum, StDrain, StCdf, StSwap, StClr} state_e;

  state_e             state_q, state_d;
  logic [8:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]   cum_q, cum_d;
  logic               bank_sel_q, bank_sel_d;
  logic               pix_dropped_q, pix_dropped_d;
  logic               lut_ready_q;
  logic [7:0]         lut_rd_data_q;

  // Increment pipeline: stage s1 holds the bin whose read data sits in rd_q.
  logic               s1_vld_q;
  logic [7:0]         s1_addr_q;
  logic               wr_vld_q;
  logic [7:0]         wr_addr_q;
  logic [CNT_W-1:0]   wr_data_q;

  // CDF pipeline: c1 accumulates, c2 scales and writes the LUT.
  logic               c1_vld_q, c2_vld_q;
  logic [7:0]         c1_idx_q, c2_idx_q;

  logic [CNT_W-1:0]   hist_mem [256];
  logic [7:0]         lut_mem  [512];
  logic [CNT_W-1:0]   rd_q;

  logic               accept, drop, acc_we, cdf_issue;
  logic [CNT_W-1:0]   base, inc;
  logic [PROD_W-1:0]  prod;
  logic [HI_W-1:0]    hi;
  logic [7:0]         map_val;

  logic               hist_we;
  logic [7:0]         hist_wa, hist_ra;
  logic [CNT_W-1:0]   hist_wd;
  logic               lut_we;
  logic [8:0]         lut_wa;
  logic [7:0]         lut_wd;

  assign accept = (state_q == StAccum) && pixel_valid_in &&
                  !(frame_start && (pix_cnt_q != '0));
  assign drop   = pixel_valid_in && !accept;

  // The write of the previous cycle is not yet visible in rd_q for a same-bin read.
  assign base   = (wr_vld_q && (wr_addr_q == s1_addr_q)) ? wr_data_q : rd_q;
  assign inc    = base + CNT_W'(1);
  assign acc_we = s1_vld_q && ((state_q == StAccum) || (state_q == StDrain));

  assign cdf_issue = (state_q == StCdf) && !cnt_q[8];
  assign hist_ra   = (state_q == StCdf) ? cnt_q[7:0] : luma_in;

  assign prod    = PROD_W'(cum_q) * PROD_W'(SCALE_V);
  assign hi      = HI_W'(prod >> 24);
  assign map_val = (hi > HI_W'(255)) ? 8'hff : hi[7:0];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pix_cnt_d     = pix_cnt_q;
    cum_d         = cum_q;
    bank_sel_d    = bank_sel_q;
    pix_dropped_d = pix_dropped_q | drop;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + 9'd1;
        if (cnt_q[7:0] == 8'hff) begin
          state_d = StAccum;
          cnt_d   = '0;
        end
      end
      StAccum: begin
        if (frame_start && (pix_cnt_q != '0)) begin
          state_d = StClr;
          cnt_d   = '0;
        end else if (accept) begin
          pix_cnt_d = pix_cnt_q + CNT_W'(1);
          if (pix_cnt_q == LAST_CNT) begin
            state_d = StDrain;
            cnt_d   = '0;
          end
        end
      end
      StDrain: begin
        cum_d = '0;
        if (cnt_q[0]) begin
          state_d = StCdf;
          cnt_d   = '0;
        end else begin
          cnt_d = 9'd1;
        end
      end
      StCdf: begin
        if (cdf_issue) cnt_d = cnt_q + 9'd1;
        if (c1_vld_q)  cum_d = cum_q + rd_q;
        if (c2_vld_q && (c2_idx_q == 8'hff)) state_d = StSwap;
      end
      StSwap: begin
        bank_sel_d = ~bank_sel_q;
        pix_cnt_d  = '0;
        state_d    = StAccum;
      end
      StClr: begin
        pix_cnt_d = '0;
        cnt_d     = cnt_q + 9'd1;
        if (cnt_q[7:0] == 8'hff) begin
          state_d = StAccum;
          cnt_d   = '0;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    hist_we = 1'b0;
    hist_wa = '0;
    hist_wd = '0;
    lut_we  = 1'b0;
    lut_wa  = '0;
    lut_wd  = '0;
    case (state_q)
      StInit: begin
        hist_we = 1'b1;
        hist_wa = cnt_q[7:0];
        lut_we  = 1'b1;
        lut_wa  = {bank_sel_q, cnt_q[7:0]};
        lut_wd  = cnt_q[7:0];
      end
      StClr: begin
        hist_we = 1'b1;
        hist_wa = cnt_q[7:0];
      end
      StAccum, StDrain: begin
        hist_we = acc_we;
        hist_wa = s1_addr_q;
        hist_wd = inc;
      end
      StCdf: begin
        hist_we = c1_vld_q;
        hist_wa = c1_idx_q;
        lut_we  = c2_vld_q;
        lut_wa  = {~bank_sel_q, c2_idx_q};
        lut_wd  = map_val;
      end
      default: ;
    endcase
    if (rst) begin
      hist_we = 1'b0;
      lut_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (hist_we) hist_mem[hist_wa] <= hist_wd;
    rd_q <= hist_mem[hist_ra];
  end

  always_ff @(posedge clk) begin
    if (lut_we) lut_mem[lut_wa] <= lut_wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StInit;
      cnt_q         <= '0;
      pix_cnt_q     <= '0;
      cum_q         <= '0;
      bank_sel_q    <= 1'b0;
      pix_dropped_q <= 1'b0;
      lut_ready_q   <= 1'b0;
      lut_rd_data_q <= '0;
      s1_vld_q      <= 1'b0;
      s1_addr_q     <= '0;
      wr_vld_q      <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      c1_vld_q      <= 1'b0;
      c1_idx_q      <= '0;
      c2_vld_q      <= 1'b0;
      c2_idx_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      cum_q         <= cum_d;
      bank_sel_q    <= bank_sel_d;
      pix_dropped_q <= pix_dropped_d;
      lut_ready_q   <= (state_q == StSwap);
      lut_rd_data_q <= lut_mem[{bank_sel_q, lut_rd_addr}];
      s1_vld_q      <= accept;
      s1_addr_q     <= luma_in;
      wr_vld_q      <= acc_we;
      wr_addr_q     <= s1_addr_q;
      wr_data_q     <= inc;
      c1_vld_q      <= cdf_issue;
      c1_idx_q      <= cnt_q[7:0];
      c2_vld_q      <= c1_vld_q;
      c2_idx_q      <= c1_idx_q;
    end
  end

  assign lut_rd_data = lut_rd_data_q;
  assign lut_ready   = lut_ready_q;
  assign busy        = (state_q != StAccum);
  assign pix_dropped = pix_dropped_q;

endmodule

// File: tb/tb_hist_cdf_lut.sv
// Self-checking bench for hist_cdf_lut on a reduced 32x32 frame; expected LUTs come from a
// histogram/CDF model computed directly from the pixels the bench sends.
module tb_hist_cdf_lut;

  localparam int unsigned H  = 32;
  localparam int unsigned V  = 32;
  localparam int unsigned CW = 11;
  localparam int unsigned N  = H * V;
  localparam longint unsigned SCALE = ((longint'(255) << 24) + longint'(N) - 1) / longint'(N);

  logic       clk = 1'b0;
  logic       rst;
  logic       pixel_valid_in;
  logic       frame_start;
  logic [7:0] luma_in;
  logic [7:0] lut_rd_addr;
  logic [7:0] lut_rd_data;
  logic       lut_ready;
  logic       busy;
  logic       pix_dropped;

  hist_cdf_lut #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .pixel_valid_in (pixel_valid_in),
    .frame_start    (frame_start),
    .luma_in        (luma_in),
    .lut_rd_addr    (lut_rd_addr),
    .lut_rd_data    (lut_rd_data),
    .lut_ready      (lut_ready),
    .busy           (busy),
    .pix_dropped    (pix_dropped)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ready_cnt = 0;

  always @(posedge clk) if (lut_ready === 1'b1) ready_cnt <= ready_cnt + 1;

  logic [7:0]  frame_q[$];
  int unsigned hist_m[256];
  logic [7:0]  exp_lut[256];
  logic [7:0]  got_lut[256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_model();
    longint unsigned cum = 0;
    longint unsigned v;
    foreach (hist_m[i]) hist_m[i] = 0;
    foreach (frame_q[j]) hist_m[frame_q[j]]++;
    for (int b = 0; b < 256; b++) begin
      cum += hist_m[b];
      v = (cum * SCALE) >> 24;
      exp_lut[b] = (v > 255) ? 8'd255 : 8'(v);
    end
  endtask

  task automatic drive_frame(input bit gaps, input bit fs_first);
    foreach (frame_q[j]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          pixel_valid_in = 1'b0;
          luma_in = 8'($urandom);
          tick();
        end
      end
      pixel_valid_in = 1'b1;
      luma_in        = frame_q[j];
      frame_start    = fs_first && (j == 0);
      tick();
      pixel_valid_in = 1'b0;
      frame_start    = 1'b0;
    end
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (lut_ready !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  task automatic read_lut();
    for (int a = 0; a < 256; a++) begin
      lut_rd_addr = 8'(a);
      tick();
      got_lut[a] = lut_rd_data;
    end
  endtask

  task automatic test_reset();
    int first_bad = -1;
    int r0;
    logic [7:0] addrs [4];
    addrs[0] = 8'd0; addrs[1] = 8'd1; addrs[2] = 8'd128; addrs[3] = 8'd255;
    rst = 1'b1; pixel_valid_in = 1'b0; frame_start = 1'b0; luma_in = '0; lut_rd_addr = '0;
    tick();
    tick();
    tests++;
    if (busy !== 1'b1 || lut_ready !== 1'b0 || pix_dropped !== 1'b0 || lut_rd_data !== 8'd0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b ready=%b dropped=%b data=%0d expected 1 0 0 0",
               busy, lut_ready, pix_dropped, lut_rd_data);
    end
    rst = 1'b0;
    r0 = ready_cnt;
    for (int i = 0; i < 260; i++) begin
      if (first_bad < 0 && busy !== (i < 256)) first_bad = i;
      tick();
    end
    tests++;
    if (first_bad != -1) begin
      fails++;
      $display("FAIL init_busy_window: got wrong busy at cycle %0d expected busy for cycles 0..255 only",
               first_bad);
    end
    tests++;
    if (ready_cnt != r0) begin
      fails++;
      $display("FAIL init_no_ready: got %0d pulses expected 0", ready_cnt - r0);
    end
    for (int k = 0; k < 4; k++) begin
      lut_rd_addr = addrs[k];
      tick();
      tests++;
      if (lut_rd_data !== addrs[k]) begin
        fails++;
        $display("FAIL identity_lut[%0d]: got %0d expected %0d", addrs[k], lut_rd_data, addrs[k]);
      end
    end
  endtask

  task automatic test_uniform_frame();
    int lat;
    int r0;
    frame_q.delete();
    for (int j = 0; j < N; j++) frame_q.push_back(8'd100);
    build_model();
    lut_rd_addr = 8'd200;
    r0 = ready_cnt;
    drive_frame(1'b0, 1'b1);
    wait_ready(lat);
    tests++;
    if (lat > 262) begin
      fails++;
      $display("FAIL uniform_latency: got %0d cycles expected <= 262", lat);
    end
    tests++;
    if (lut_rd_data !== 8'd200) begin
      fails++;
      $display("FAIL swap_read_old_bank: got %0d expected 200", lut_rd_data);
    end
    tick();
    tests++;
    if (lut_rd_data !== exp_lut[200]) begin
      fails++;
      $display("FAIL swap_read_new_bank: got %0d expected %0d", lut_rd_data, exp_lut[200]);
    end
    repeat (5) tick();
    tests++;
    if (ready_cnt - r0 != 1) begin
      fails++;
      $display("FAIL uniform_ready_once: got %0d pulses expected 1", ready_cnt - r0);
    end
    read_lut();
    tests++;
    if (got_lut[99] !== 8'd0 || got_lut[100] !== 8'd255) begin
      fails++;
      $display("FAIL uniform_edges: got lut[99]=%0d lut[100]=%0d expected 0 255", got_lut[99], got_lut[100]);
    end
    for (int a = 0; a < 256; a++) begin
      tests++;
      if (got_lut[a] !== exp_lut[a]) begin
        fails++;
        $display("FAIL uniform_lut[%0d]: got %0d expected %0d", a, got_lut[a], exp_lut[a]);
      end
    end
    tests++;
    if (pix_dropped !== 1'b0) begin
      fails++;
      $display("FAIL uniform_no_drop: got %b expected 0", pix_dropped);
    end
  endtask

  task automatic test_interleaved();
    int lat;
    frame_q.delete();
    for (int j = 0; j < N; j++) frame_q.push_back(8'((j * 167) + (j >> 8)));
    build_model();
    drive_frame(1'b1, 1'b1);
    wait_ready(lat);
    tests++;
    if (lat > 262) begin
      fails++;
      $display("FAIL interleaved_latency: got %0d cycles expected <= 262", lat);
    end
    tick();
    read_lut();
    tests++;
    if (got_lut[0] !== 8'd0 || got_lut[127] !== 8'd127 || got_lut[255] !== 8'd255) begin
      fails++;
      $display("FAIL interleaved_points: got %0d %0d %0d expected 0 127 255",
               got_lut[0], got_lut[127], got_lut[255]);
    end
    for (int a = 0; a < 256; a++) begin
      tests++;
      if (got_lut[a] !== exp_lut[a]) begin
        fails++;
        $display("FAIL interleaved_lut[%0d]: got %0d expected %0d", a, got_lut[a], exp_lut[a]);
      end
    end
  endtask

  task automatic random_frame();
    frame_q.delete();
    for (int j = 0; j < N; j++) begin
      if ($urandom_range(0, 3) == 0) frame_q.push_back(8'($urandom));
      else frame_q.push_back(8'(60 + $urandom_range(0, 3)));
    end
    build_model();
  endtask

  task automatic test_drop_during_cdf();
    int lat;
    tests++;
    if (pix_dropped !== 1'b0) begin
      fails++;
      $display("FAIL pre_drop_clear: got %b expected 0", pix_dropped);
    end
    random_frame();
    drive_frame(1'b1, 1'b0);
    repeat (20) tick();
    for (int i = 0; i < 8; i++) begin
      pixel_valid_in = 1'b1;
      luma_in = 8'($urandom);
      tick();
    end
    pixel_valid_in = 1'b0;
    tests++;
    if (pix_dropped !== 1'b1) begin
      fails++;
      $display("FAIL drop_set: got %b expected 1", pix_dropped);
    end
    wait_ready(lat);
    tick();
    read_lut();
    for (int a = 0; a < 256; a++) begin
      tests++;
      if (got_lut[a] !== exp_lut[a]) begin
        fails++;
        $display("FAIL drop_frame_a_lut[%0d]: got %0d expected %0d", a, got_lut[a], exp_lut[a]);
      end
    end
    random_frame();
    drive_frame(1'b1, 1'b1);
    wait_ready(lat);
    tests++;
    if (lat > 262) begin
      fails++;
      $display("FAIL drop_frame_b_latency: got %0d cycles expected <= 262", lat);
    end
    tick();
    read_lut();
    for (int a = 0; a < 256; a++) begin
      tests++;
      if (got_lut[a] !== exp_lut[a]) begin
        fails++;
        $display("FAIL drop_frame_b_lut[%0d]: got %0d expected %0d", a, got_lut[a], exp_lut[a]);
      end
    end
    tests++;
    if (pix_dropped !== 1'b1) begin
      fails++;
      $display("FAIL drop_sticky: got %b expected 1", pix_dropped);
    end
  endtask

  task automatic test_partial_frame();
    int lat;
    int c;
    int r0;
    logic [7:0] prev_lut[256];
    prev_lut = exp_lut;
    frame_q.delete();
    for (int j = 0; j < 1000; j++) frame_q.push_back(8'd77);
    drive_frame(1'b0, 1'b0);
    r0 = ready_cnt;
    pixel_valid_in = 1'b1; luma_in = 8'd50; frame_start = 1'b1;
    tick();
    pixel_valid_in = 1'b0; frame_start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL partial_clear_busy: got %b expected 1", busy);
    end
    c = 0;
    while (busy === 1'b1 && c < 300) begin
      tick();
      c++;
    end
    tests++;
    if (c != 256) begin
      fails++;
      $display("FAIL partial_clear_len: got %0d cycles expected 256", c);
    end
    tests++;
    if (ready_cnt != r0) begin
      fails++;
      $display("FAIL partial_no_ready: got %0d pulses expected 0", ready_cnt - r0);
    end
    read_lut();
    for (int a = 0; a < 256; a++) begin
      tests++;
      if (got_lut[a] !== prev_lut[a]) begin
        fails++;
        $display("FAIL partial_lut_kept[%0d]: got %0d expected %0d", a, got_lut[a], prev_lut[a]);
      end
    end
    frame_q.delete();
    for (int j = 0; j < N; j++) frame_q.push_back(8'd50);
    build_model();
    drive_frame(1'b0, 1'b1);
    wait_ready(lat);
    tick();
    read_lut();
    tests++;
    if (got_lut[49] !== 8'd0 || got_lut[50] !== 8'd255) begin
      fails++;
      $display("FAIL partial_edges: got lut[49]=%0d lut[50]=%0d expected 0 255", got_lut[49], got_lut[50]);
    end
    for (int a = 0; a < 256; a++) begin
      tests++;
      if (got_lut[a] !== exp_lut[a]) begin
        fails++;
        $display("FAIL partial_next_lut[%0d]: got %0d expected %0d", a, got_lut[a], exp_lut[a]);
      end
    end
  endtask

  task automatic test_reset_mid_cdf();
    int r0;
    random_frame();
    drive_frame(1'b1, 1'b0);
    repeat (100) tick();
    r0 = ready_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (busy !== 1'b1 || pix_dropped !== 1'b0 || lut_rd_data !== 8'd0) begin
      fails++;
      $display("FAIL midcdf_reset_outputs: got busy=%b dropped=%b data=%0d expected 1 0 0",
               busy, pix_dropped, lut_rd_data);
    end
    repeat (300) tick();
    tests++;
    if (ready_cnt != r0) begin
      fails++;
      $display("FAIL midcdf_no_ready: got %0d pulses expected 0", ready_cnt - r0);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL midcdf_idle: got busy=%b expected 0", busy);
    end
    read_lut();
    for (int a = 0; a < 256; a++) begin
      tests++;
      if (got_lut[a] !== 8'(a)) begin
        fails++;
        $display("FAIL midcdf_identity[%0d]: got %0d expected %0d", a, got_lut[a], a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_uniform_frame();
    test_interleaved();
    test_drop_during_cdf();
    test_partial_frame();
    test_reset_mid_cdf();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hist_cdf_lut.md
Name: hist_cdf_lut

Overview:
Equalization-mapping generator for the luminance path of the Retinex/HE pipeline.
- Accumulates a 256-bin luminance histogram over one active frame.
- In the blanking interval, runs a single 256-cycle pass that builds the cumulative distribution and converts it to an 8-bit equalization LUT.
- Publishes the LUT through a double-buffered read port to the downstream pixel-remap stage; the remap stage is never stalled.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- CNT_W, 19, histogram bin / pixel counter width; must hold H_ACTIVE*V_ACTIVE.
- Derived localparam N = H_ACTIVE*V_ACTIVE.
- Derived localparam SCALE = ceil(255*2^24 / N); equals 13927 at defaults.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- pixel_valid_in  in  1  luma_in is an active-area pixel this cycle
- frame_start  in  1  one-cycle pulse, coincident with or before the first pixel of a frame
- luma_in  in  8  pixel luminance
- lut_rd_addr  in  8  remap-stage lookup address
- lut_rd_data  out  8  published LUT entry; registered, 1-cycle latency
- lut_ready  out  1  one-cycle pulse when a new LUT bank is published
- busy  out  1  high in any state other than ACCUM
- pix_dropped  out  1  sticky; set when a valid pixel arrives while not in ACCUM

Behaviour:
Storage:
- Histogram RAM: 256 x CNT_W.
- Two LUT banks: 256 x 8 each.
- bank_sel selects the published bank; the other bank is the write bank.

Reset (rst=1 at a clock edge):
- State goes to INIT; pix_cnt=0, bank_sel=0, lut_ready=0, pix_dropped=0, lut_rd_data=0, busy=1.
- Reset mid-operation abandons everything and restarts INIT.

States:
- INIT (256 cycles, i=0..255): write hist[i]=0 and published_bank[i]=i (identity LUT). Then go to ACCUM. Pixels arriving here are ignored and set pix_dropped.
- ACCUM: each valid pixel does hist[luma_in] += 1, pix_cnt += 1.
  - The read-modify-write is pipelined: read, add, write.
  - Same-bin hits in back-to-back or gap-1 cycles must be forwarded, so that no increment is lost at one pixel per clock.
  - When the increment that brings pix_cnt to N is accepted, go to DRAIN.
- DRAIN (2 cycles): flush the increment pipeline, then go to CDF with cum=0.
- CDF (256 cycles, i=0..255), pipelined with read latency absorbed:
  - cum += hist[i]
  - write_bank[i] = min(255, (cum*SCALE) >> 24); the product is CNT_W+14 bits, no truncation before the shift.
  - Write hist[i]=0 (clears the histogram for the next frame).
  - After the last write, go to SWAP.
- SWAP (1 cycle): toggle bank_sel, pulse lut_ready=1, set pix_cnt=0, go to ACCUM.
- CLR (256 cycles): write hist[i]=0, set pix_cnt=0, then go to ACCUM. The LUT is unchanged.

Boundary conditions:
- frame_start in ACCUM with pix_cnt≠0 (partial frame) discards the partial histogram: go to CLR. The pixel in that same cycle is dropped and sets pix_dropped.
- frame_start with pix_cnt=0 is a no-op; a valid pixel in the same cycle is accumulated.
- frame_start outside ACCUM is ignored.
- Valid pixels arriving in DRAIN, CDF, SWAP or CLR are discarded and set pix_dropped.
- The LUT read port always reads the published bank and is unaffected by CDF writes. A read in the SWAP cycle returns the old bank; the following cycle returns the new bank.
- With exactly N valid pixels per frame, cum never exceeds N and the final entry evaluates to 255. The clamp guards against SCALE rounding.
- pix_cnt does not wrap; N is the terminal count.

Latency:
- Last pixel to lut_ready is 2 + 256 + pipeline depth (≤3) + 1 cycles; must be ≤ 262 at defaults.

Test Plan:
- Reset, then hold 260 cycles. Required: busy=1 for 256 cycles, then 0. lut_rd_data = addr for addr in {0, 1, 128, 255}. lut_ready never asserted.
- One full frame with every pixel luma=100 at one pixel per clock (forwarding stress). Required: lut_ready pulses once. lut[0..99]=0, lut[100..255]=255.
- Frame in which each value 0..255 appears exactly 1200 times, interleaved. Required: lut[0]=0, lut[127]=127, lut[255]=255. All entries match the golden formula (cum*13927)>>24.
- Pixel valid during CDF. Required: pix_dropped=1 and stays 1. The next frame's LUT is built from exactly N pixels.
- frame_start after 1000 pixels, then a full frame of luma=50. Required: the partial frame is discarded. lut[49]=0, lut[50]=255.
- rst asserted mid-CDF. Required: INIT rerun, identity LUT republished, no lut_ready pulse.
